// File: rtl/conv_encoder_k3.sv
// Purpose : rate-1/2, K=3 convolutional encoder (G0=111, G1=101); each frame of
//           FRAME_LEN information bits is followed by two zero tail bits so the
//           trellis always returns to state 0.
// Latency : one cycle; a bit accepted at edge k is presented on o_sym after edge k.
// Backpressure: single output register; while o_valid && !i_ready the symbol holds,
//           o_ready drops and no tail symbol is generated.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             frame start request, honoured only when idle and not busy
//   i_valid, i_bit      information bit input, accepted when i_valid && o_ready
//   o_ready             encoder takes i_bit this cycle
//   o_sym[1:0]          code symbol {c0, c1}
//   o_valid, i_ready    output handshake
//   o_last              final tail symbol of the frame, qualified by o_valid
//   o_busy              frame in progress or symbol still pending
module conv_encoder_k3 #(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic       i_bit,
  output logic       o_ready,
  output logic [1:0] o_sym,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_busy
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;     // u[n-1]
  logic             s2_q, s2_d;     // u[n-2]
  logic             tail2_q, tail2_d; // next tail symbol is the second (final) one
  logic [1:0]       sym_q, sym_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;

  logic slot_free;
  logic accept;
  logic tail_load;
  logic load;
  logic u;

  // The output register can take a new symbol when empty or being drained.
  assign slot_free = !vld_q || i_ready;
  assign accept    = (state_q == DATA) && slot_free && i_valid;
  assign tail_load = (state_q == TAIL) && slot_free;
  assign load      = accept || tail_load;
  // Tail bits are zero; data bits come straight from the source.
  assign u         = accept & i_bit;

  assign o_ready = (state_q == DATA) && slot_free;
  assign o_busy  = (state_q != IDLE) || vld_q;
  assign o_sym   = sym_q;
  assign o_valid = vld_q;
  assign o_last  = last_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    tail2_d = tail2_q;
    sym_d   = sym_q;
    vld_d   = vld_q;
    last_d  = last_q;

    // Drain first; a same-cycle load below overrides it.
    if (vld_q && i_ready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    if (load) begin
      sym_d  = {u ^ s1_q ^ s2_q, u ^ s2_q};
      s1_d   = u;
      s2_d   = s1_q;
      vld_d  = 1'b1;
      last_d = tail_load && tail2_q;
    end

    case (state_q)
      IDLE: begin
        if (i_start && !o_busy) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = TAIL;
            tail2_d = 1'b0;
          end
        end
      end
      TAIL: begin
        if (tail_load) begin
          if (tail2_q) begin
            // Two zero tails flushed s1/s2 back to 00, so no clear is needed.
            state_d = IDLE;
            tail2_d = 1'b0;
          end else begin
            tail2_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      tail2_q <= 1'b0;
      sym_q   <= 2'b00;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      tail2_q <= tail2_d;
      sym_q   <= sym_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Purpose : directed self-checking bench for conv_encoder_k3 with FRAME_LEN 4, 16 and 1.
// Latency : inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: i_ready is driven per test; consumed symbols are collected on a queue.
module tb_conv_encoder_k3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      start_w, valid_w, bit_w, ready_w;
  logic [2:0][1:0] sym_w;
  logic [2:0]      ovalid_w, olast_w, oready_w, busy_w;

  conv_encoder_k3 #(.FRAME_LEN(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w[0]), .i_valid(valid_w[0]),
    .i_bit(bit_w[0]), .o_ready(oready_w[0]), .o_sym(sym_w[0]), .o_valid(ovalid_w[0]),
    .i_ready(ready_w[0]), .o_last(olast_w[0]), .o_busy(busy_w[0])
  );

  conv_encoder_k3 #(.FRAME_LEN(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w[1]), .i_valid(valid_w[1]),
    .i_bit(bit_w[1]), .o_ready(oready_w[1]), .o_sym(sym_w[1]), .o_valid(ovalid_w[1]),
    .i_ready(ready_w[1]), .o_last(olast_w[1]), .o_busy(busy_w[1])
  );

  conv_encoder_k3 #(.FRAME_LEN(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w[2]), .i_valid(valid_w[2]),
    .i_bit(bit_w[2]), .o_ready(oready_w[2]), .o_sym(sym_w[2]), .o_valid(ovalid_w[2]),
    .i_ready(ready_w[2]), .o_last(olast_w[2]), .o_busy(busy_w[2])
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         cur = 0;
  logic [2:0] got_q[$];   // {last, sym} of every consumed symbol
  logic [1:0] exp_q[$];

  // A symbol visible with i_ready high at the falling edge is consumed on the next rise.
  always @(negedge clk) begin
    if (rst_n && ovalid_w[cur] && ready_w[cur])
      got_q.push_back({olast_w[cur], sym_w[cur]});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int d);
    start_w[d] = 1'b1;
    tick();
    start_w[d] = 1'b0;
    #3;
    check("ready_after_start", oready_w[d], 1);
  endtask

  // Offer bits[0..n-1] in order, holding each until accepted. With gap set,
  // two idle cycles follow every bit except the last.
  task automatic send_bits(input int d, input logic [15:0] bits, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   budget;
      valid_w[d] = 1'b1;
      bit_w[d]   = bits[i];
      acc        = 1'b0;
      budget     = 0;
      while (!acc && budget < 50) begin
        @(negedge clk);
        acc = oready_w[d];
        budget++;
        tick();
      end
      check($sformatf("accept%0d", i), acc, 1);
      if (gap && i < n - 1) begin
        valid_w[d] = 1'b0;
        tick();
        @(negedge clk);
        check($sformatf("gap_idle%0d", i), ovalid_w[d], 0);
        tick();
      end
    end
    valid_w[d] = 1'b0;
  endtask

  task automatic wait_frame_end(input int d);
    bit found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (ovalid_w[d] && olast_w[d] && ready_w[d]) found = 1'b1;
    end
    check("last_seen", found, 1);
    if (found) begin
      check("busy_at_last", busy_w[d], 1);
      @(negedge clk);
      check("busy_after_last", busy_w[d], 0);
    end
  endtask

  task automatic compare_seq(input string tag);
    int n = exp_q.size();
    check($sformatf("%s_len", tag), got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), got_q[i], {(i == n - 1), exp_q[i]});
  endtask

  task automatic load_golden();
    exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_w = '0;
    valid_w = '0;
    bit_w   = '0;
    ready_w = 3'b111;
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_sym%0d", d),   sym_w[d],    0);
      check($sformatf("rst_valid%0d", d), ovalid_w[d], 0);
      check($sformatf("rst_last%0d", d),  olast_w[d],  0);
      check($sformatf("rst_ready%0d", d), oready_w[d], 0);
      check($sformatf("rst_busy%0d", d),  busy_w[d],   0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // Golden frame 1,0,1,1 with free-running sink.
    cur = 0;
    got_q.delete();
    load_golden();
    start_frame(0);
    send_bits(0, 16'h000D, 4, 1'b0);
    wait_frame_end(0);
    compare_seq("golden");

    // Backpressure while the second symbol is pending.
    got_q.delete();
    start_frame(0);
    valid_w[0] = 1'b1;
    bit_w[0]   = 1'b1;
    tick();
    bit_w[0] = 1'b0;
    tick();
    bit_w[0]   = 1'b1;
    ready_w[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_sym%0d", c), sym_w[0], 2'b10);
      check($sformatf("bp_hold_vld%0d", c), ovalid_w[0], 1);
      check($sformatf("bp_hold_rdy%0d", c), oready_w[0], 0);
      tick();
    end
    ready_w[0] = 1'b1;
    send_bits(0, 16'h0003, 2, 1'b0);
    wait_frame_end(0);
    compare_seq("bp");

    // i_start during DATA and while the final symbol is pending is ignored.
    got_q.delete();
    start_frame(0);
    send_bits(0, 16'h0001, 2, 1'b0);
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    #3;
    check("start_mid_busy", busy_w[0], 1);
    send_bits(0, 16'h0003, 2, 1'b0);
    tick();
    tick();
    ready_w[0] = 1'b0;
    start_w[0] = 1'b1;
    @(negedge clk);
    check("pend_last", olast_w[0], 1);
    check("pend_sym", sym_w[0], 2'b11);
    check("pend_busy", busy_w[0], 1);
    tick();
    start_w[0] = 1'b0;
    @(negedge clk);
    check("pend_hold_vld", ovalid_w[0], 1);
    check("pend_no_ready", oready_w[0], 0);
    ready_w[0] = 1'b1;
    tick();
    @(negedge clk);
    check("ignored_start_busy", busy_w[0], 0);
    check("ignored_start_ready", oready_w[0], 0);
    compare_seq("start1");
    got_q.delete();
    start_frame(0);
    send_bits(0, 16'h000D, 4, 1'b0);
    wait_frame_end(0);
    compare_seq("start2");

    // Asynchronous reset after two accepted bits, then a clean frame.
    got_q.delete();
    start_frame(0);
    send_bits(0, 16'h0001, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", ovalid_w[0], 0);
    check("arst_last", olast_w[0], 0);
    check("arst_busy", busy_w[0], 0);
    check("arst_ready", oready_w[0], 0);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    start_frame(0);
    send_bits(0, 16'h000D, 4, 1'b0);
    wait_frame_end(0);
    compare_seq("rst");

    // FRAME_LEN=16, all ones, source gaps of two cycles.
    cur = 1;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    for (int i = 0; i < 14; i++) exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    start_frame(1);
    send_bits(1, 16'hFFFF, 16, 1'b1);
    wait_frame_end(1);
    compare_seq("gap");

    // FRAME_LEN=1 with bit 1.
    cur = 2;
    got_q.delete();
    exp_q = '{2'b11, 2'b10, 2'b11};
    start_frame(2);
    send_bits(2, 16'h0001, 1, 1'b0);
    wait_frame_end(2);
    compare_seq("len1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
